i_cache: RTL and testbench
==========================

// Module: i_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the core fetch stage and the
//  instruction/backing memory. Hits return the 32-bit word one cycle after the request.
//  Misses issue a single-word fetch to memory, fill the line, then return the word.
//  No writes, no write-back, no prefetch.
// PARAMETERS
//  CACHE_SIZE  1024  number of cache lines; one 32-bit word per line; power of two, >=2
//  derived: IDX_W=$clog2(CACHE_SIZE); TAG_W=30-IDX_W
// PORTS
//  clk                   in   1   clock; all state updates on rising edge
//  reset                 in   1   asynchronous, active-low reset
//  read_request          in   1   fetch request; level, sampled each clk while idle
//  addr                  in   32  byte fetch address
//  read_response         out  1   one-cycle pulse: read_data valid
//  read_data             out  32  fetched instruction word
//  memory_read_request   out  1   miss fetch request; held high until memory_read_response
//  memory_read_response  in   1   memory has data on memory_read_data this cycle
//  memory_addr           out  32  word-aligned miss address
//  memory_read_data      in   32  memory word
// BEHAVIOUR
//  - Address split: addr[1:0] ignored; the word containing addr is returned
//    (0x6 -> word 0x4, 0xE -> word 0xC). Index=addr[IDX_W+1:2], tag=addr[31:IDX_W+2].
//  - Storage: data[CACHE_SIZE] x32, tag[CACHE_SIZE] x TAG_W, valid[CACHE_SIZE] x1.
//  - Reset (reset=0, async): all valid bits 0, state IDLE, read_response=0,
//    read_data=0, memory_read_request=0, memory_addr=0. Data/tag arrays not cleared.
//    A reset during a miss aborts it; memory_read_request drops immediately.
//  - FSM states: IDLE, MISS, FILL.
//    IDLE: if read_request=1, latch addr word-aligned into req_addr.
//      hit (valid & tag match): next edge read_response=1, read_data=data[idx];
//      stay IDLE. Back-to-back hits therefore produce one response per cycle,
//      each for the address sampled on the previous edge.
//      miss: next edge memory_read_request=1, memory_addr=req_addr; go MISS;
//      read_response=0.
//      If read_request=0: read_response=0, read_data holds its last value.
//    MISS: hold memory_read_request and memory_addr stable; addr/read_request ignored.
//      On an edge with memory_read_response=1: write data/tag of req_addr line;
//      set valid; read_data=memory_read_data; read_response=1;
//      memory_read_request=0; go FILL.
//    FILL: read_response=0; return to IDLE next edge. One bubble cycle; a re-request
//      of the same address then hits.
//  - read_response is never high for two consecutive cycles across a miss completion.
//  - Addresses aliasing to one index evict each other (direct-mapped, no replacement state).
//  - Memory latency is arbitrary (>=1 cycle); the cache waits indefinitely.
//  - A response that arrives while memory_read_request=0 is ignored.
// TESTING
//  1 reset=0 for 5 clk, then release -> all outputs 0; first fetch of 0x0 misses:
//    memory_read_request=1, memory_addr=0x0.
//  2 cold miss 0x0 with memory word 0x00000013 -> read_response pulse, read_data=0x00000013;
//    re-request 0x0 -> hit, response 1 clk later, no memory request.
//  3 sequential 0x0,0x4,0x8 held 4 clk each, cold -> three misses with memory_addr
//    0x0,0x4,0x8; repeat the sequence -> all hits.
//  4 misaligned 0x6 after 0x4 filled -> hit returning word 0x4;
//    0xE cold -> miss with memory_addr=0xC.
//  5 alias test: fetch 0x0 then 0x1000 (CACHE_SIZE=1024) -> both miss;
//    refetch 0x0 -> miss again (evicted).
//  6 assert reset while in MISS -> memory_read_request=0 immediately;
//    after release, fetch 0x0 misses (valid cleared).

Source files
------------

// File: rtl/i_cache.sv
// i_cache: direct-mapped read-only instruction cache, one 32-bit word per line.
// Hits answer one cycle after the request; misses fetch a single word from memory.
module i_cache #(
    parameter int CACHE_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_request,
    input  logic [31:0] addr,
    output logic        read_response,
    output logic [31:0] read_data,
    output logic        memory_read_request,
    input  logic        memory_read_response,
    output logic [31:0] memory_addr,
    input  logic [31:0] memory_read_data
);
    localparam int IDX_W = $clog2(CACHE_SIZE);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

    state_t                  state;
    logic [31:0]             data_mem [CACHE_SIZE];
    logic [TAG_W-1:0]        tag_mem  [CACHE_SIZE];
    logic [CACHE_SIZE-1:0]   valid;
    logic [IDX_W-1:0]        idx, fill_idx;
    logic [TAG_W-1:0]        tag, fill_tag;
    logic                    hit;
    logic                    unused_bits;

    assign idx         = addr[IDX_W+1:2];
    assign tag         = addr[31:IDX_W+2];
    assign hit         = valid[idx] && tag_mem[idx] == tag;
    assign unused_bits = ^addr[1:0];
    // memory_addr holds the missing word address for the whole miss, so it doubles as req_addr
    assign fill_idx    = memory_addr[IDX_W+1:2];
    assign fill_tag    = memory_addr[31:IDX_W+2];

    always_ff @(posedge clk) begin
        if (state == MISS && memory_read_response) begin
            data_mem[fill_idx] <= memory_read_data;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            valid               <= '0;
            read_response       <= 1'b0;
            read_data           <= '0;
            memory_read_request <= 1'b0;
            memory_addr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    read_response <= read_request && hit;
                    if (read_request && hit) begin
                        read_data <= data_mem[idx];
                    end else if (read_request) begin
                        memory_read_request <= 1'b1;
                        memory_addr         <= {addr[31:2], 2'b00};
                        state               <= MISS;
                    end
                end
                MISS: begin
                    if (memory_read_response) begin
                        valid[fill_idx]     <= 1'b1;
                        read_data           <= memory_read_data;
                        read_response       <= 1'b1;
                        memory_read_request <= 1'b0;
                        state               <= FILL;
                    end
                end
                FILL: begin
                    read_response <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i_cache.sv
// tb_i_cache: scenario tasks drive fetches, a queue holds expected words,
// and each response pops and compares against the backing-memory model.
module tb_i_cache;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read_request = 1'b0;
    logic [31:0] addr = '0;
    logic        read_response;
    logic [31:0] read_data;
    logic        memory_read_request;
    logic        memory_read_response = 1'b0;
    logic [31:0] memory_addr;
    logic [31:0] memory_read_data = '0;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q [$];

    i_cache #(.CACHE_SIZE(1024)) dut (
        .clk(clk), .reset(reset), .read_request(read_request), .addr(addr),
        .read_response(read_response), .read_data(read_data),
        .memory_read_request(memory_read_request), .memory_read_response(memory_read_response),
        .memory_addr(memory_addr), .memory_read_data(memory_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        return (wa == 32'h0) ? 32'h0000_0013 : {wa[15:0] ^ 16'hBEEF, wa[15:0]};
    endfunction

    task automatic fetch(input logic [31:0] a, input logic exp_miss, input int lat);
        logic [31:0] wa;
        logic [31:0] exp;
        wa = {a[31:2], 2'b00};
        @(negedge clk);
        addr = a;
        read_request = 1'b1;
        exp_q.push_back(mem_word(wa));
        @(negedge clk);
        read_request = 1'b0;
        compared++;
        if (memory_read_request !== exp_miss) begin
            mismatched++;
            $display("FAIL miss_req addr=%h got=%b exp=%b", a, memory_read_request, exp_miss);
        end
        if (exp_miss) begin
            compared++;
            if (memory_addr !== wa) begin
                mismatched++;
                $display("FAIL miss_addr addr=%h got=%h exp=%h", a, memory_addr, wa);
            end
            compared++;
            if (read_response !== 1'b0) begin
                mismatched++;
                $display("FAIL miss_no_resp addr=%h got=%b exp=0", a, read_response);
            end
            for (int i = 1; i < lat; i++) begin
                addr = ~a;
                read_request = 1'b1;
                @(negedge clk);
                compared++;
                if (memory_read_request !== 1'b1 || memory_addr !== wa) begin
                    mismatched++;
                    $display("FAIL miss_hold addr=%h got req=%b maddr=%h exp req=1 maddr=%h",
                             a, memory_read_request, memory_addr, wa);
                end
            end
            read_request = 1'b0;
            addr = a;
            memory_read_response = 1'b1;
            memory_read_data = mem_word(memory_addr);
            @(negedge clk);
            memory_read_response = 1'b0;
            compared++;
            if (memory_read_request !== 1'b0) begin
                mismatched++;
                $display("FAIL req_drop addr=%h got=%b exp=0", a, memory_read_request);
            end
        end
        exp = exp_q.pop_front();
        compared++;
        if (read_response !== 1'b1) begin
            mismatched++;
            $display("FAIL resp addr=%h got=%b exp=1", a, read_response);
        end
        compared++;
        if (read_data !== exp) begin
            mismatched++;
            $display("FAIL data addr=%h got=%h exp=%h", a, read_data, exp);
        end
        if (exp_miss) begin
            @(negedge clk);
            compared++;
            if (read_response !== 1'b0) begin
                mismatched++;
                $display("FAIL fill_bubble addr=%h got=%b exp=0", a, read_response);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        read_request = 1'b0;
        memory_read_response = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({read_response, memory_read_request} !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_flags got=%b%b exp=00", read_response, memory_read_request);
        end
        compared++;
        if (read_data !== 32'h0 || memory_addr !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_words got data=%h maddr=%h exp 0/0", read_data, memory_addr);
        end
        fetch(32'h0, 1'b1, 3);
        fetch(32'h0, 1'b0, 1);
    endtask

    task automatic test_sequential();
        do_reset();
        fetch(32'h0, 1'b1, 1);
        fetch(32'h4, 1'b1, 2);
        fetch(32'h8, 1'b1, 4);
        fetch(32'h0, 1'b0, 1);
        fetch(32'h4, 1'b0, 1);
        fetch(32'h8, 1'b0, 1);
    endtask

    task automatic test_misaligned();
        fetch(32'h6, 1'b0, 1);
        fetch(32'hE, 1'b1, 2);
        fetch(32'hD, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h6};
        logic [31:0] exp;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp = exp_q.pop_front();
                compared++;
                if (read_response !== 1'b1 || read_data !== exp) begin
                    mismatched++;
                    $display("FAIL b2b_%0d got resp=%b data=%h exp resp=1 data=%h", i - 1, read_response, read_data, exp);
                end
            end
            addr = seq[i];
            read_request = 1'b1;
            exp_q.push_back(mem_word({seq[i][31:2], 2'b00}));
        end
        @(negedge clk);
        read_request = 1'b0;
        exp = exp_q.pop_front();
        compared++;
        if (read_response !== 1'b1 || read_data !== exp) begin
            mismatched++;
            $display("FAIL b2b_4 got resp=%b data=%h exp resp=1 data=%h", read_response, read_data, exp);
        end
        @(negedge clk);
        compared++;
        if (read_response !== 1'b0 || read_data !== exp || memory_read_request !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_idle got resp=%b data=%h req=%b exp resp=0 data=%h req=0",
                     read_response, read_data, memory_read_request, exp);
        end
    endtask

    task automatic test_spurious_response();
        @(negedge clk);
        memory_read_response = 1'b1;
        memory_read_data = 32'hDEAD_BEEF;
        @(negedge clk);
        memory_read_response = 1'b0;
        compared++;
        if (read_response !== 1'b0 || memory_read_request !== 1'b0) begin
            mismatched++;
            $display("FAIL spurious got resp=%b req=%b exp 0/0", read_response, memory_read_request);
        end
        fetch(32'h4, 1'b0, 1);
    endtask

    task automatic test_alias();
        fetch(32'h1000, 1'b1, 2);
        fetch(32'h0, 1'b1, 1);
        fetch(32'h1000, 1'b1, 3);
        fetch(32'h1000, 1'b0, 1);
    endtask

    task automatic test_reset_in_miss();
        @(negedge clk);
        addr = 32'h40;
        read_request = 1'b1;
        @(negedge clk);
        read_request = 1'b0;
        compared++;
        if (memory_read_request !== 1'b1) begin
            mismatched++;
            $display("FAIL rim_req got=%b exp=1", memory_read_request);
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if (memory_read_request !== 1'b0 || memory_addr !== 32'h0 || read_response !== 1'b0) begin
            mismatched++;
            $display("FAIL rim_async got req=%b maddr=%h resp=%b exp 0/0/0", memory_read_request, memory_addr, read_response);
        end
        @(negedge clk);
        reset = 1'b1;
        fetch(32'h0, 1'b1, 1);
        fetch(32'h0, 1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_misaligned();
        test_back_to_back();
        test_spurious_response();
        test_alias();
        test_reset_in_miss();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
